// File: rtl/snow64_instr_cache_pkg.sv
// Shared types and address helpers for the snow64 direct-mapped instruction cache.
// Contents:
//   - geometry localparams (line count, address/line/instruction widths, field widths)
//   - typedefs for index, tag, offset, line, instruction and address
//   - packed port structs for the IF/ID side and the memory-arbiter side
//   - controller state enum
//   - helpers that split a byte address into offset / index / tag
package snow64_instr_cache_pkg;

    localparam int LOG2_NUM_LINES = 6;
    localparam int NUM_LINES      = 1 << LOG2_NUM_LINES;
    localparam int WIDTH_ADDR     = 64;
    localparam int WIDTH_LINE     = 256;
    localparam int WIDTH_INSTR    = 32;

    // Byte address layout: [tag | index | word offset | byte-in-word]
    localparam int WIDTH_BYTE_SEL = 2;
    localparam int WIDTH_OFFSET   = 3;
    localparam int WIDTH_INDEX    = LOG2_NUM_LINES;
    localparam int LSB_OFFSET     = WIDTH_BYTE_SEL;
    localparam int LSB_INDEX      = LSB_OFFSET + WIDTH_OFFSET;
    localparam int LSB_TAG        = LSB_INDEX + WIDTH_INDEX;
    localparam int WIDTH_TAG      = WIDTH_ADDR - LSB_TAG;

    typedef logic [WIDTH_INDEX-1:0]  index_t;
    typedef logic [WIDTH_TAG-1:0]    tag_t;
    typedef logic [WIDTH_OFFSET-1:0] offset_t;
    typedef logic [WIDTH_LINE-1:0]   line_t;
    typedef logic [WIDTH_INSTR-1:0]  instr_t;
    typedef logic [WIDTH_ADDR-1:0]   addr_t;

    typedef struct packed {
        logic  req_valid;
        addr_t req_addr;
    } port_in_from_if_id_t;

    // Field-compatible with the IF/ID instr-cache input struct {valid, instr}.
    typedef struct packed {
        logic   valid;
        instr_t instr;
    } port_out_to_if_id_t;

    typedef struct packed {
        logic  req;
        addr_t addr;
    } port_out_to_mem_t;

    typedef struct packed {
        logic  ack;
        line_t data;
    } port_in_from_mem_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_REFILL
    } state_e;

    function automatic index_t addr_index(addr_t addr);
        return addr[LSB_INDEX +: WIDTH_INDEX];
    endfunction

    function automatic tag_t addr_tag(addr_t addr);
        return addr[LSB_TAG +: WIDTH_TAG];
    endfunction

    function automatic offset_t addr_offset(addr_t addr);
        return addr[LSB_OFFSET +: WIDTH_OFFSET];
    endfunction

    function automatic addr_t line_addr(addr_t addr);
        return {addr[WIDTH_ADDR-1:LSB_INDEX], {LSB_INDEX{1'b0}}};
    endfunction

    // Word k of a line occupies bits [32k+31:32k].
    function automatic instr_t select_word(line_t line, offset_t offset);
        return line[offset * WIDTH_INSTR +: WIDTH_INSTR];
    endfunction

endpackage

// File: rtl/snow64_instr_cache_if.sv
// Bus bundle between the instruction cache, IF/ID and the memory arbiter.
// Signals:
//   in_req_valid / in_req_addr  : fetch request from IF/ID
//   out_valid / out_instr       : fetched instruction back to IF/ID (1-cycle latency on hit)
//   out_mem_req / out_mem_addr  : line-fill request to the memory arbiter
//   in_mem_ack / in_mem_data    : single-beat fill response
// Modports:
//   slave  : the cache's view
//   master : the environment's view (IF/ID + arbiter, or a testbench)
interface snow64_instr_cache_if;
    import snow64_instr_cache_pkg::*;

    logic   in_req_valid;
    addr_t  in_req_addr;
    logic   out_valid;
    instr_t out_instr;
    logic   out_mem_req;
    addr_t  out_mem_addr;
    logic   in_mem_ack;
    line_t  in_mem_data;

    modport slave (
        input  in_req_valid, in_req_addr, in_mem_ack, in_mem_data,
        output out_valid, out_instr, out_mem_req, out_mem_addr
    );

    modport master (
        output in_req_valid, in_req_addr, in_mem_ack, in_mem_data,
        input  out_valid, out_instr, out_mem_req, out_mem_addr
    );

endinterface

// File: rtl/snow64_instr_cache_line_ram.sv
// Tag + data storage for the instruction cache.
// Ports:
//   clk                          : write clock
//   wr_en, wr_index, wr_tag,
//   wr_line                      : synchronous write port (one whole line per write)
//   rd_index                     : combinational read address
//   rd_tag, rd_line              : combinational read data
// Valid bits live in the parent so reset can clear them; this array is never reset.
module snow64_instr_cache_line_ram
    import snow64_instr_cache_pkg::*;
(
    input  logic   clk,
    input  logic   wr_en,
    input  index_t wr_index,
    input  tag_t   wr_tag,
    input  line_t  wr_line,
    input  index_t rd_index,
    output tag_t   rd_tag,
    output line_t  rd_line
);

    tag_t  tag_mem  [NUM_LINES];
    line_t line_mem [NUM_LINES];

    // NOTE: storage arrays carry no reset; an entry is only trusted once its
    // valid bit (held in the parent) is set, so clearing them would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            line_mem[wr_index] <= wr_line;
        end
    end

    assign rd_tag  = tag_mem[rd_index];
    assign rd_line = line_mem[rd_index];

endmodule

// File: rtl/snow64_instr_cache.sv
// Direct-mapped, read-only instruction cache in front of the IF/ID stage.
// Ports:
//   clk : single clock, all state updates on posedge
//   rst : synchronous active-high reset, highest priority
//   bus : snow64_instr_cache_if.slave (IF/ID fetch port + memory-arbiter fill port)
// Operation: a hit returns the word one cycle after the request. A miss latches
// the line address, holds out_mem_req until the single-beat ack, writes the line,
// spends one dead cycle, then resumes lookups (IF/ID re-presents its PC).
module snow64_instr_cache
    import snow64_instr_cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    snow64_instr_cache_if.slave    bus
);

    port_in_from_if_id_t from_if_id;
    port_in_from_mem_t   from_mem;

    assign from_if_id = '{req_valid: bus.in_req_valid, req_addr: bus.in_req_addr};
    assign from_mem   = '{ack: bus.in_mem_ack, data: bus.in_mem_data};

    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    port_out_to_if_id_t     if_id_q, if_id_d;
    port_out_to_mem_t       mem_q, mem_d;

    // Storage interface: lookup indexes by the live request, fill writes at the
    // latched line address (held in mem_q.addr for the whole fill).
    logic   wr_en;
    index_t rd_index;
    tag_t   rd_tag;
    line_t  rd_line;
    logic   hit;

    assign rd_index = addr_index(from_if_id.req_addr);
    assign hit      = valid_q[rd_index] && (rd_tag == addr_tag(from_if_id.req_addr));

    snow64_instr_cache_line_ram u_line_ram (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_index (addr_index(mem_q.addr)),
        .wr_tag   (addr_tag(mem_q.addr)),
        .wr_line  (from_mem.data),
        .rd_index (rd_index),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line)
    );

    // NOTE: every signal written here is given a default before the case, so no
    // path leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        if_id_d       = if_id_q;
        if_id_d.valid = 1'b0;     // out_instr holds; out_valid is a one-cycle pulse
        mem_d         = mem_q;
        wr_en         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (from_if_id.req_valid) begin
                    if (hit) begin
                        if_id_d.valid = 1'b1;
                        if_id_d.instr = select_word(rd_line, addr_offset(from_if_id.req_addr));
                    end else begin
                        mem_d.req  = 1'b1;
                        mem_d.addr = line_addr(from_if_id.req_addr);
                        state_d    = ST_FILL;
                    end
                end
            end

            // Request inputs are ignored here; a redirect is picked up after refill.
            ST_FILL: begin
                if (from_mem.ack) begin
                    // Gated by rst so an ack coinciding with reset touches nothing.
                    wr_en                             = !rst;
                    valid_d[addr_index(mem_q.addr)]   = 1'b1;
                    mem_d.req                         = 1'b0;
                    state_d                           = ST_REFILL;
                end
            end

            ST_REFILL: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            if_id_q <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if_id_q <= if_id_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.out_valid    = if_id_q.valid;
    assign bus.out_instr    = if_id_q.instr;
    assign bus.out_mem_req  = mem_q.req;
    assign bus.out_mem_addr = mem_q.addr;

endmodule

// File: tb/tb_snow64_instr_cache.sv
// Scoreboard bench for snow64_instr_cache. A driver plays IF/ID and the memory
// arbiter; a behavioural cache model (tag/valid arrays plus a fill phase) decides
// hit/miss and pushes expected instructions and expected memory-request values
// into queues. An independent monitor pops and compares on the falling edge.
module tb_snow64_instr_cache;
    import snow64_instr_cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    snow64_instr_cache_if bus ();

    snow64_instr_cache dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int unsigned due;
        logic [31:0] instr;
    } instr_exp_t;

    typedef struct {
        int unsigned due;
        logic        req;
        logic [63:0] addr;
        logic        was_rst;
    } mem_exp_t;

    instr_exp_t instr_q [$];
    mem_exp_t   mem_q   [$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: what the cache holds, and where the fill stands.
    // ------------------------------------------------------------------
    typedef enum {P_IDLE, P_FILL, P_REFILL} phase_e;
    phase_e      phase = P_IDLE;
    bit          m_valid [64];
    logic [52:0] m_tag   [64];
    logic [63:0] fill_line = '0;
    int          fill_lat = 0;
    int          lat_cfg = 2;      // fixed ack latency, or -1 for random
    bit          force_ack = 1'b0; // one-shot stray ack
    bit          spur_en = 1'b0;   // random stray acks outside a fill

    // Backing memory contents: word k of the line at address L.
    function automatic logic [31:0] mem_word(logic [63:0] line, int k);
        return (line[31:0] ^ line[63:32]) + 32'h1000 + 32'(k);
    endfunction

    function automatic logic [255:0] mem_line(logic [63:0] line);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word(line, k);
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom();
        return l;
    endfunction

    function automatic logic [63:0] gen_addr();
        logic [63:0] r64;
        logic [52:0] t;
        logic [5:0]  idx;
        r64 = {$urandom(), $urandom()};
        t   = ($urandom_range(0, 7) == 0) ? r64[52:0] : 53'($urandom_range(0, 3));
        idx = 6'($urandom_range(0, 15));
        return {t, idx, r64[4:0]};
    endfunction

    // One clock of IF/ID + arbiter behaviour, driven on the falling edge.
    task automatic drive_cycle(input bit r, input bit v, input logic [63:0] a, output bit served);
        int unsigned due;
        logic [5:0]  idx;
        @(negedge clk);
        due    = cyc + 1;
        served = 1'b0;
        idx    = a[10:5];
        rst              = r;
        bus.in_req_valid = v;
        bus.in_req_addr  = a;
        bus.in_mem_ack   = 1'b0;
        bus.in_mem_data  = rand_line();
        if (r) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            phase = P_IDLE;
        end else begin
            case (phase)
                P_IDLE: begin
                    if (force_ack || (spur_en && $urandom_range(0, 9) == 0)) bus.in_mem_ack = 1'b1;
                    if (v) begin
                        if (m_valid[idx] && m_tag[idx] == a[63:11]) begin
                            instr_q.push_back('{due, mem_word({a[63:5], 5'b0}, int'(a[4:2]))});
                            served = 1'b1;
                        end else begin
                            fill_line = {a[63:5], 5'b0};
                            fill_lat  = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 4));
                            phase     = P_FILL;
                        end
                    end
                end
                P_FILL: begin
                    if (fill_lat == 0) begin
                        bus.in_mem_ack               = 1'b1;
                        bus.in_mem_data              = mem_line(fill_line);
                        m_valid[fill_line[10:5]]     = 1'b1;
                        m_tag[fill_line[10:5]]       = fill_line[63:11];
                        phase                        = P_REFILL;
                    end else begin
                        fill_lat--;
                    end
                end
                default: begin
                    if (spur_en && $urandom_range(0, 9) == 0) bus.in_mem_ack = 1'b1;
                    phase = P_IDLE;
                end
            endcase
        end
        force_ack = 1'b0;
        mem_q.push_back('{due, (phase == P_FILL), fill_line, r});
    endtask

    // IF/ID holding a PC until the model says it has been served.
    task automatic present(input logic [63:0] a);
        bit s;
        int n;
        s = 1'b0;
        n = 0;
        while (!s && n < 60) begin
            drive_cycle(1'b0, 1'b1, a, s);
            n++;
        end
        if (!s) begin
            n_checks++;
            n_errors++;
            $display("FAIL present_timeout: address %h not served after %0d cycles", a, n);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [31:0] hold_instr = '0;

    always @(negedge clk) begin
        mem_exp_t   me;
        instr_exp_t ie;
        while (mem_q.size() != 0 && mem_q[0].due < cyc) void'(mem_q.pop_front());
        if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
            me = mem_q.pop_front();
            if (me.was_rst) hold_instr = '0;
            check("mem_req", 64'(bus.out_mem_req), 64'(me.req));
            if (me.req) check("mem_addr", bus.out_mem_addr, me.addr);
        end
        if (bus.out_valid === 1'b1) begin
            if (instr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid @cycle %0d: out_valid=1 instr=%h, expected no output", cyc, bus.out_instr);
            end else begin
                ie = instr_q.pop_front();
                check("instr_cycle", 64'(cyc), 64'(ie.due));
                check("instr", 64'(bus.out_instr), 64'(ie.instr));
                hold_instr = ie.instr;
            end
        end else begin
            if (bus.out_valid !== 1'b0) check("valid_known", 64'(bus.out_valid), 64'(0));
            if (instr_q.size() != 0 && instr_q[0].due <= cyc) begin
                ie = instr_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL missing_valid @cycle %0d: out_valid=0, expected instr %h", cyc, ie.instr);
            end
            check("instr_hold", 64'(bus.out_instr), 64'(hold_instr));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit          s;
        logic [63:0] a;
        bus.in_req_valid = 1'b0;
        bus.in_req_addr  = '0;
        bus.in_mem_ack   = 1'b0;
        bus.in_mem_data  = '0;

        drive_cycle(1'b1, 1'b0, 64'h0, s);
        drive_cycle(1'b1, 1'b0, 64'h0, s);
        @(posedge clk);
        #1;
        check("rst_valid",    64'(bus.out_valid),   64'(0));
        check("rst_instr",    64'(bus.out_instr),   64'(0));
        check("rst_mem_req",  64'(bus.out_mem_req), 64'(0));
        check("rst_mem_addr", bus.out_mem_addr,     64'h0);

        // Cold start miss, then hit on word 0.
        present(64'h0);
        // Streaming hits.
        present(64'h4);
        present(64'h8);
        present(64'hC);
        // Last word of the line, then the next line misses.
        present(64'h1C);
        present(64'h20);
        // Conflict eviction at index 0.
        present(64'h800);
        present(64'h0);
        // Redirect during a fill: 0x40 completes, then 0x100 is fetched.
        drive_cycle(1'b0, 1'b1, 64'h40, s);
        present(64'h100);
        present(64'h40);
        // Reset mid-fill, then a late ack that must not write.
        present(64'h0);
        lat_cfg = 6;
        drive_cycle(1'b0, 1'b1, 64'h60, s);
        drive_cycle(1'b0, 1'b0, 64'h0, s);
        drive_cycle(1'b0, 1'b0, 64'h0, s);
        drive_cycle(1'b1, 1'b0, 64'h0, s);
        force_ack = 1'b1;
        drive_cycle(1'b0, 1'b0, 64'h0, s);
        present(64'h0);
        present(64'h60);

        // Randomized traffic: gaps, sequential runs, redirects, stray acks, resets.
        lat_cfg = -1;
        spur_en = 1'b1;
        a = gen_addr();
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), a, s);
            if (s) a = ($urandom_range(0, 2) == 0) ? gen_addr() : a + 64'd4;
            else if (phase == P_FILL && $urandom_range(0, 5) == 0) a = gen_addr();
        end

        spur_en = 1'b0;
        for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b0, 64'h0, s);
        @(negedge clk);
        check("instr_q_drained", 64'(instr_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
